// File: rtl/output_mem_ctrl.sv
// rtl/output_mem_ctrl.sv - skewed column write, row-aligned read buffer for systolic array results
module output_mem_ctrl #(
    parameter int SYS_COL   = 16,
    parameter int ACC_WIDTH = 32,
    parameter int ACCUM_ROW = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   num_row,
    input  logic                         accum_en,
    input  logic [SYS_COL-1:0]           col_valid,
    input  logic [SYS_COL*ACC_WIDTH-1:0] col_data,
    output logic                         wr_done,
    input  logic                         rd_start,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SYS_COL*ACC_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         err_cfg,
    output logic                         err_overflow
);

    localparam int AW = $clog2(ACCUM_ROW);
    localparam logic [7:0] MAX_ROW = 8'(ACCUM_ROW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WAIT_RD = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     num_row_q;
    logic           accum_en_q;
    logic [7:0]     wr_cnt_q [SYS_COL];
    logic [7:0]     rd_ptr_q;
    logic           err_cfg_q, err_cfg_d;
    logic           err_ovf_q;

    logic [ACC_WIDTH-1:0] mem [ACCUM_ROW][SYS_COL];

    logic               start_ok;
    logic               accept_cfg;
    logic               all_full;
    logic               ovf_hit;
    logic               xfer;
    logic [SYS_COL-1:0] wr_en;

    // Per-column write enables, overflow detection and completion detection
    always_comb begin
        wr_en    = '0;
        ovf_hit  = 1'b0;
        all_full = 1'b1;
        for (int j = 0; j < SYS_COL; j++) begin
            if (wr_cnt_q[j] != num_row_q) begin
                all_full = 1'b0;
            end
            if (col_valid[j]) begin
                if (state_q == COLLECT) begin
                    if (wr_cnt_q[j] < num_row_q) begin
                        wr_en[j] = 1'b1;
                    end else begin
                        ovf_hit = 1'b1;
                    end
                end else if (state_q == WAIT_RD || state_q == DRAIN) begin
                    ovf_hit = 1'b1;
                end
            end
        end
    end

    // Next-state logic and Moore/handshake outputs; rd_start beats start in WAIT_RD
    always_comb begin
        state_d    = state_q;
        wr_done    = 1'b0;
        start_ok   = start && (num_row != 8'd0) && (num_row <= MAX_ROW);
        accept_cfg = 1'b0;
        err_cfg_d  = 1'b0;
        out_valid  = (state_q == DRAIN);
        out_last   = (state_q == DRAIN) && (rd_ptr_q == num_row_q - 8'd1);
        xfer       = out_valid && out_ready;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d    = COLLECT;
                    accept_cfg = 1'b1;
                end else if (start) begin
                    err_cfg_d = 1'b1;
                end
            end
            COLLECT: begin
                if (all_full) begin
                    wr_done = 1'b1;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (rd_start) begin
                    state_d = DRAIN;
                end else if (start_ok) begin
                    state_d    = COLLECT;
                    accept_cfg = 1'b1;
                end else if (start) begin
                    err_cfg_d = 1'b1;
                end
            end
            DRAIN: begin
                if (xfer && out_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: state, pass config, column counters, read pointer, error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            num_row_q  <= 8'd0;
            accum_en_q <= 1'b0;
            rd_ptr_q   <= 8'd0;
            err_cfg_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            for (int j = 0; j < SYS_COL; j++) begin
                wr_cnt_q[j] <= 8'd0;
            end
        end else begin
            state_q   <= state_d;
            err_cfg_q <= err_cfg_d;
            if (accept_cfg) begin
                num_row_q  <= num_row;
                accum_en_q <= accum_en;
                err_ovf_q  <= 1'b0;
                for (int j = 0; j < SYS_COL; j++) begin
                    wr_cnt_q[j] <= 8'd0;
                end
            end else begin
                if (ovf_hit) begin
                    err_ovf_q <= 1'b1;
                end
                for (int j = 0; j < SYS_COL; j++) begin
                    if (wr_en[j]) begin
                        wr_cnt_q[j] <= wr_cnt_q[j] + 8'd1;
                    end
                end
            end
            if (state_q == WAIT_RD && rd_start) begin
                rd_ptr_q <= 8'd0;
            end else if (xfer) begin
                rd_ptr_q <= out_last ? 8'd0 : rd_ptr_q + 8'd1;
            end
        end
    end

    // Storage: single-cycle read-modify-write per column, deliberately not reset
    always_ff @(posedge clk) begin
        for (int j = 0; j < SYS_COL; j++) begin
            if (wr_en[j]) begin
                mem[wr_cnt_q[j][AW-1:0]][j] <= accum_en_q
                    ? mem[wr_cnt_q[j][AW-1:0]][j] + col_data[j*ACC_WIDTH +: ACC_WIDTH]
                    : col_data[j*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    // Row read at the registered pointer, zero outside DRAIN
    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < SYS_COL; j++) begin
                out_data[j*ACC_WIDTH +: ACC_WIDTH] = mem[rd_ptr_q[AW-1:0]][j];
            end
        end
    end

    assign err_cfg      = err_cfg_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_output_mem_ctrl.sv
// tb/tb_output_mem_ctrl.sv - self-checking bench for output_mem_ctrl
module tb_output_mem_ctrl;

    localparam int NC = 16;
    localparam int AWD = 32;
    localparam int NR = 128;
    localparam int W = NC * AWD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    num_row = 8'd0;
    logic          accum_en = 1'b0;
    logic [NC-1:0] col_valid = '0;
    logic [W-1:0]  col_data = '0;
    logic          wr_done;
    logic          rd_start = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          err_cfg;
    logic          err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [AWD-1:0] exp_mem [NR][NC];
    logic           exp_ovf = 1'b0;

    output_mem_ctrl #(.SYS_COL(NC), .ACC_WIDTH(AWD), .ACCUM_ROW(NR)) dut (
        .clk(clk), .rst(rst), .start(start), .num_row(num_row), .accum_en(accum_en),
        .col_valid(col_valid), .col_data(col_data), .wr_done(wr_done),
        .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy),
        .err_cfg(err_cfg), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_row(input int r);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < NC; j++) v[j*AWD +: AWD] = exp_mem[r][j];
        return v;
    endfunction

    // pattern: 0 = (r<<8)|j, 1 = random. extra_col gets one surplus strobe (dropped).
    task automatic collect(input int nrow, input bit acc, input bit rnd, input int extra_col);
        logic [AWD-1:0] d;
        start = 1'b1; num_row = 8'(nrow); accum_en = acc;
        tick();
        start = 1'b0;
        exp_ovf = 1'b0;
        chk("collect_busy", W'(busy), W'(1));
        chk("collect_ovf_clr", W'(err_overflow), W'(0));
        for (int t = 0; t < nrow + NC - 1; t++) begin
            col_valid = '0;
            col_data  = '0;
            for (int j = 0; j < NC; j++) begin
                int r;
                r = t - j;
                if (r >= 0 && r < nrow) begin
                    d = rnd ? AWD'($urandom) : AWD'((r << 8) | j);
                    col_valid[j] = 1'b1;
                    col_data[j*AWD +: AWD] = d;
                    exp_mem[r][j] = acc ? exp_mem[r][j] + d : d;
                end else if (j == extra_col && r == nrow) begin
                    col_valid[j] = 1'b1;
                    col_data[j*AWD +: AWD] = AWD'($urandom);
                    exp_ovf = 1'b1;
                end
            end
            if (t == nrow + NC - 2) chk("wr_done_early", W'(wr_done), W'(0));
            tick();
        end
        col_valid = '0;
        col_data  = '0;
        chk("wr_done_pulse", W'(wr_done), W'(1));
        chk("collect_ovf", W'(err_overflow), W'(exp_ovf));
        tick();
        chk("wr_done_low", W'(wr_done), W'(0));
        chk("wait_rd_busy", W'(busy), W'(1));
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random
    task automatic drain(input int nrow, input int rmode);
        int idx = 0;
        int cyc = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        while (idx < nrow && cyc < 2000) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            chk("out_valid", W'(out_valid), W'(1));
            chk($sformatf("out_data_r%0d", idx), out_data, exp_row(idx));
            chk("out_last", W'(out_last), W'(idx == nrow - 1));
            if (out_ready) idx++;
            cyc++;
            tick();
        end
        out_ready = 1'b0;
        chk("drain_count", W'(idx), W'(nrow));
        chk("drain_idle_busy", W'(busy), W'(0));
        chk("drain_idle_valid", W'(out_valid), W'(0));
        chk("drain_idle_data", out_data, W'(0));
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_wr_done", W'(wr_done), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_last", W'(out_last), W'(0));
        chk("rst_err_cfg", W'(err_cfg), W'(0));
        chk("rst_err_ovf", W'(err_overflow), W'(0));
        chk("rst_out_data", out_data, W'(0));

        // IDLE strobes are ignored without flagging
        col_valid = '1;
        tick();
        col_valid = '0;
        chk("idle_strobe_no_flag", W'(err_overflow), W'(0));

        // T1: pattern, no accumulation, always ready
        collect(8, 1'b0, 1'b0, -1);
        drain(8, 0);

        // T2: two passes of the pattern, second accumulates from WAIT_RD
        collect(8, 1'b0, 1'b0, -1);
        collect(8, 1'b1, 1'b0, -1);
        drain(8, 0);

        // T3: random data, toggled ready
        collect(8, 1'b0, 1'b1, -1);
        drain(8, 1);

        // T4: surplus strobe on column 3, flag sticky through drain
        collect(4, 1'b0, 1'b1, 3);
        drain(4, 0);
        chk("ovf_sticky", W'(err_overflow), W'(1));

        // strobe in WAIT_RD flags overflow; the next start clears it
        collect(5, 1'b0, 1'b1, -1);
        col_valid = 16'h0001;
        tick();
        col_valid = '0;
        chk("wait_rd_strobe_flag", W'(err_overflow), W'(1));
        drain(5, 2);

        // T5: illegal num_row values
        start = 1'b1; num_row = 8'd0;
        tick();
        start = 1'b0;
        chk("cfg0_err", W'(err_cfg), W'(1));
        chk("cfg0_busy", W'(busy), W'(0));
        tick();
        chk("cfg0_pulse_end", W'(err_cfg), W'(0));
        start = 1'b1; num_row = 8'd129;
        tick();
        start = 1'b0;
        chk("cfg129_err", W'(err_cfg), W'(1));
        chk("cfg129_busy", W'(busy), W'(0));
        tick();
        chk("cfg129_pulse_end", W'(err_cfg), W'(0));

        // T6: reset after 3 of 8 rows
        start = 1'b1; num_row = 8'd8; accum_en = 1'b0;
        tick();
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            col_valid = '1;
            col_data = {NC{AWD'($urandom)}};
            tick();
        end
        col_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", W'(busy), W'(0));
        chk("t6_wr_done", W'(wr_done), W'(0));
        chk("t6_out_valid", W'(out_valid), W'(0));
        collect(8, 1'b0, 1'b1, -1);
        drain(8, 0);

        // Boundaries and random multi-pass accumulation
        collect(1, 1'b0, 1'b1, -1);
        drain(1, 2);
        collect(128, 1'b0, 1'b1, -1);
        drain(128, 0);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 24);
            collect(n, 1'b0, 1'b1, -1);
            collect(n, 1'b1, 1'b1, -1);
            drain(n, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
